mant_addsub_norm: RTL and testbench



---
 rtl/float_pkg.sv | 24 ++
 rtl/lzc_count.sv | 20 ++
 rtl/mant_addsub_norm.sv | 162 ++++++++++++++++
 tb/tb_mant_addsub_norm.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared float constants and helpers for the FC add/sub datapath stages.
package float_pkg;

    localparam int EW      = 8;
    localparam int MW      = 23;
    localparam int FW      = 1 + EW + MW;
    localparam int EXP_MAX = (1 << EW) - 1;

    localparam logic [FW-1:0] FLOAT_ZERO = '0;

    function automatic int clog2i(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int mini(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/lzc_count.sv
// Leading-zero counter; an all-zero input reports W.
module lzc_count
    import float_pkg::*;
#(
    parameter int W  = float_pkg::MW + 1,
    parameter int CW = clog2i(W + 1)
) (
    input  logic [W-1:0]  data_i,
    output logic [CW-1:0] cnt_o
);

    // Scan upward so the highest set bit has the final word.
    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) cnt_o = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/mant_addsub_norm.sv
// Mantissa add/sub, normalise and pack: 3-stage valid/ready pipeline.
// Define MANT_ROUND_NEAREST_EN for round-to-nearest on the carry/lz=0 paths.
module mant_addsub_norm
    import float_pkg::*;
#(
    parameter int EW = float_pkg::EW,
    parameter int MW = float_pkg::MW,
    parameter int FW = float_pkg::FW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [EW:0]   exp_i,
    input  logic          equal_i,
    input  logic          close_i,
    input  logic          round_1_i,
    input  logic          sgn_big_i,
    input  logic          sgn_small_i,
    input  logic [MW:0]   mantisa0_i,
    input  logic [MW:0]   mantisa1_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [FW-1:0] float_o
);

    localparam int XW = EW + 2;
    localparam int CW = clog2i(MW + 2);
    localparam logic [EW:0] EMAX = (EW+1)'((1 << EW) - 1);

    logic en;
    logic v1_q, v2_q, vo_q;
    logic [FW-1:0] flt_q, flt_d;

    assign en      = ~vo_q | ready_i;
    assign ready_o = en;
    assign valid_o = vo_q;
    assign float_o = flt_q;

    // ---------------- S1: add / subtract ----------------
    logic          eff_sub;
    logic [MW+1:0] sum, dif, mag1_d, mag1_q;
    logic          sgn1_d, sgn1_q, zero1_q, sub1_q;
    logic [XW-1:0] exp1_q;

    always_comb begin
        eff_sub = sgn_big_i ^ sgn_small_i;
        sum     = {1'b0, mantisa0_i} + {1'b0, mantisa1_i};
        dif     = {1'b0, mantisa0_i} - {1'b0, mantisa1_i};
        mag1_d  = sum;
        sgn1_d  = sgn_big_i;
        if (eff_sub) begin
            mag1_d = dif;
            // Negative difference only arises with equal exponents.
            if (dif[MW+1]) begin
                mag1_d = -dif;
                sgn1_d = ~sgn_big_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            mag1_q  <= mag1_d;
            sgn1_q  <= sgn1_d;
            zero1_q <= (mag1_d == '0);
            sub1_q  <= eff_sub;
            exp1_q  <= {1'b0, exp_i};
        end
    end

`ifdef MANT_ROUND_NEAREST_EN
    logic rnd1_q;
    always_ff @(posedge clk_i) begin
        if (en) rnd1_q <= round_1_i;
    end
`endif

    // ---------------- S2: normalise ----------------
    logic [CW-1:0] lz;
    logic          carry;
    logic [MW:0]   shf, mant2_d, mant2_q;
    logic [XW-1:0] exp2_d, exp2_q;
    logic          sgn2_q, zero2_q;

    lzc_count #(.W(MW + 1), .CW(CW)) u_lzc (
        .data_i (mag1_q[MW:0]),
        .cnt_o  (lz)
    );

`ifdef MANT_ROUND_NEAREST_EN
    logic [MW+1:0] rnd;
    logic          rnd_en;
`endif

    always_comb begin
        carry   = ~sub1_q & mag1_q[MW+1];
        shf     = mag1_q[MW:0] << lz;
        mant2_d = shf;
        exp2_d  = exp1_q - XW'(lz);
        if (carry) begin
            mant2_d = mag1_q[MW+1:1];
            exp2_d  = exp1_q + XW'(1);
        end
`ifdef MANT_ROUND_NEAREST_EN
        rnd_en = carry | (sub1_q & (lz == '0));
        if (carry)
            rnd = {1'b0, mag1_q[MW+1:1]} + {{(MW+1){1'b0}}, mag1_q[0]};
        else
            rnd = {1'b0, mag1_q[MW:0]} + {{(MW+1){1'b0}}, rnd1_q};
        // A rounding carry-out renormalises by one more position.
        if (rnd_en) begin
            mant2_d = rnd[MW+1] ? rnd[MW+1:1] : rnd[MW:0];
            exp2_d  = exp2_d + XW'(rnd[MW+1]);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            mant2_q <= mant2_d;
            exp2_q  <= exp2_d;
            sgn2_q  <= sgn1_q;
            zero2_q <= zero1_q;
        end
    end

    // ---------------- S3: pack ----------------
    always_comb begin
        flt_d = FLOAT_ZERO;
        if (zero2_q)
            flt_d = FLOAT_ZERO;
        else if (exp2_q[XW-1] || exp2_q == '0)
            flt_d = {sgn2_q, {(FW-1){1'b0}}};
        else if (exp2_q[EW:0] >= EMAX)
            flt_d = {sgn2_q, {EW{1'b1}}, {MW{1'b0}}};
        else
            flt_d = {sgn2_q, exp2_q[EW-1:0], mant2_q[MW-1:0]};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            vo_q  <= 1'b0;
            flt_q <= FLOAT_ZERO;
        end else if (en) begin
            v1_q  <= valid_i;
            v2_q  <= v1_q;
            vo_q  <= v2_q;
            flt_q <= flt_d;
        end
    end

    logic unused_ok;
`ifdef MANT_ROUND_NEAREST_EN
    assign unused_ok = ^{close_i, equal_i, mant2_q[MW]};
`else
    assign unused_ok = ^{close_i, equal_i, round_1_i, mant2_q[MW]};
`endif

endmodule

// File: tb/tb_mant_addsub_norm.sv
// Scoreboard bench for mant_addsub_norm with a behavioural float reference.
module tb_mant_addsub_norm;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [8:0]  exp_i;
    logic        equal_i, close_i, round_1_i;
    logic        sgn_big_i, sgn_small_i;
    logic [23:0] mantisa0_i, mantisa1_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] float_o;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    bit rnd_rdy = 0;
    logic [31:0] exp_q[$];

    mant_addsub_norm dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .exp_i       (exp_i),
        .equal_i     (equal_i),
        .close_i     (close_i),
        .round_1_i   (round_1_i),
        .sgn_big_i   (sgn_big_i),
        .sgn_small_i (sgn_small_i),
        .mantisa0_i  (mantisa0_i),
        .mantisa1_i  (mantisa1_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .float_o     (float_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: exact integer add/sub, then normalise into [2^23, 2^24).
    function automatic logic [31:0] model(input int e, input int m0, input int m1,
                                          input bit sb, input bit ss, input bit r1);
        int r, mag, ex;
        bit sg;
        sg = sb;
        r  = (sb ^ ss) ? (m0 - m1) : (m0 + m1);
        if (r < 0) begin
            r  = -r;
            sg = ~sb;
        end
        if (r == 0) return 32'h0;
        mag = r;
        ex  = e;
        if (mag >= (1 << 24)) begin
`ifdef MANT_ROUND_NEAREST_EN
            mag = (mag >> 1) + (mag & 1);
            ex++;
            if (mag >= (1 << 24)) begin
                mag >>= 1;
                ex++;
            end
`else
            mag >>= 1;
            ex++;
`endif
        end else if (mag >= (1 << 23)) begin
`ifdef MANT_ROUND_NEAREST_EN
            if (sb ^ ss) begin
                mag += int'(r1);
                if (mag >= (1 << 24)) begin
                    mag >>= 1;
                    ex++;
                end
            end
`endif
        end else begin
            while (mag < (1 << 23)) begin
                mag <<= 1;
                ex--;
            end
        end
        if (ex <= 0) return {sg, 31'h0};
        if (ex >= 255) return {sg, 8'hFF, 23'h0};
        return {sg, ex[7:0], mag[22:0]};
    endfunction

    task automatic send(input int e, input int a, input int b, input bit sb,
                        input bit ss, input bit eq, input bit r1,
                        input logic [31:0] expv);
        int n;
        n = 0;
        @(posedge clk_i);
        #1;
        valid_i     = 1'b1;
        exp_i       = 9'(e);
        mantisa0_i  = 24'(a);
        mantisa1_i  = 24'(b);
        sgn_big_i   = sb;
        sgn_small_i = ss;
        equal_i     = eq;
        close_i     = eq;
        round_1_i   = r1;
        @(negedge clk_i);
        while (!ready_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        checks++;
        if (!ready_o) begin
            errors++;
            $display("FAIL send_timeout: ready_o=%0b after %0d cycles, required 1", ready_o, n);
        end else begin
            exp_q.push_back(expv);
        end
    endtask

    task automatic idle();
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic send_rand();
        int e, a, b, sh;
        bit sb, ss, r1, eq;
        case ($urandom % 4)
            0: e = $urandom_range(1, 4);
            1: e = $urandom_range(250, 255);
            default: e = $urandom_range(1, 254);
        endcase
        a  = 32'h800000 | $urandom_range(0, 32'h7FFFFF);
        b  = 32'h800000 | $urandom_range(0, 32'h7FFFFF);
        sh = $urandom_range(0, 25);
        if ($urandom % 8 == 0) begin
            b  = a;
            sh = 0;
        end
        b  = b >> sh;
        eq = (sh == 0);
        sb = 1'($urandom);
        ss = 1'($urandom);
        r1 = 1'($urandom);
        send(e, a, b, sb, ss, eq, r1, model(e, a, b, sb, ss, r1));
    endtask

    always @(posedge clk_i) begin
        if (rnd_rdy) begin
            #1;
            ready_i = ($urandom % 4) != 0;
        end
    end

    // Monitor: ready rule, stall stability and in-order scoreboard.
    bit          pv = 0, pr = 0;
    logic [31:0] pf = '0;
    always @(negedge clk_i) begin
        logic [31:0] e;
        if (rst_i) begin
            pv = 0;
        end else begin
            checks++;
            if (ready_o !== (!valid_o || ready_i)) begin
                errors++;
                $display("FAIL ready_rule: ready_o=%0b, required %0b", ready_o, !valid_o || ready_i);
            end
            if (pv && !pr) begin
                checks++;
                if (valid_o !== 1'b1 || float_o !== pf) begin
                    errors++;
                    $display("FAIL stall_hold: valid_o=%0b float_o=%h, required 1 %h", valid_o, float_o, pf);
                end
            end
            if (valid_o && ready_i) begin
                checks++;
                n_out++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: float_o=%h with no beat outstanding", float_o);
                end else begin
                    e = exp_q.pop_front();
                    if (float_o !== e) begin
                        errors++;
                        $display("FAIL result: float_o=%h, required %h", float_o, e);
                    end
                end
            end
            pv = valid_o;
            pr = ready_i;
            pf = float_o;
        end
    end

    initial begin
        int n0;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        exp_i = '0; equal_i = 0; close_i = 0; round_1_i = 0;
        sgn_big_i = 0; sgn_small_i = 0; mantisa0_i = '0; mantisa1_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (valid_o !== 1'b0 || float_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid_o=%0b float_o=%h, required 0 0", valid_o, float_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_o=%0b, required 1", ready_o);
        end

        // Directed vectors with hand-computed results.
        send(127, 32'h800000, 32'h800000, 0, 0, 1, 0, 32'h40000000);
        send(127, 32'hC00000, 32'hC00000, 0, 1, 1, 0, 32'h00000000);
        send(127, 32'h800000, 32'hC00000, 0, 1, 1, 0, 32'hBF000000);
        send(254, 32'h800000, 32'h800000, 0, 0, 1, 0, 32'h7F800000);
        send(1,   32'h800000, 32'h7FFFFF, 0, 1, 0, 0, 32'h00000000);
        idle();
        drain();

        // Six-beat stream with a three-cycle downstream stall.
        n0 = n_out;
        fork
            begin
                send(127, 32'h800000, 32'h400000, 0, 0, 0, 0, model(127, 32'h800000, 32'h400000, 0, 0, 0));
                send(130, 32'hA00000, 32'h100000, 1, 1, 0, 0, model(130, 32'hA00000, 32'h100000, 1, 1, 0));
                send(100, 32'hF00000, 32'h0F0000, 0, 1, 0, 0, model(100, 32'hF00000, 32'h0F0000, 0, 1, 0));
                send(5,   32'h900000, 32'h880000, 1, 0, 1, 0, model(5, 32'h900000, 32'h880000, 1, 0, 0));
                send(200, 32'hFFFFFF, 32'hFFFFFF, 0, 0, 1, 0, model(200, 32'hFFFFFF, 32'hFFFFFF, 0, 0, 0));
                send(64,  32'h812345, 32'h000001, 1, 0, 0, 1, model(64, 32'h812345, 32'h000001, 1, 0, 1));
                idle();
            end
            begin
                repeat (4) @(posedge clk_i);
                #1;
                ready_i = 1'b0;
                repeat (3) @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();
        checks++;
        if (n_out - n0 != 6) begin
            errors++;
            $display("FAIL stream_count: %0d beats out, required 6", n_out - n0);
        end

        // Randomised traffic with random back-pressure.
        rnd_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            send_rand();
            if ($urandom % 5 == 0) idle();
        end
        idle();
        rnd_rdy = 0;
        @(posedge clk_i);
        #2;
        ready_i = 1'b1;
        drain();

        // Reset with three beats in flight.
        send(127, 32'h800000, 32'h800000, 0, 0, 1, 0, 32'h40000000);
        send(128, 32'h800000, 32'h800000, 0, 0, 1, 0, 32'h40800000);
        send(129, 32'h800000, 32'h800000, 0, 0, 1, 0, 32'h41000000);
        idle();
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid_o=%0b, required 0", valid_o);
        end
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        n0 = n_out;
        repeat (8) @(posedge clk_i);
        #1;
        checks++;
        if (n_out != n0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: %0d stale outputs valid_o=%0b, required 0 0", n_out - n0, valid_o);
        end

        send(127, 32'h800000, 32'h800000, 0, 0, 1, 0, 32'h40000000);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
